// File: rtl/regbank_pkg.sv
// regbank_pkg
// Shared constants for the decode-stage register bank with load scoreboard.
//   DW_DEF    : default data width
//   NREG_DEF  : default number of architectural registers
//   NREAD_DEF : default number of combinational read ports
//   ZERO_REG  : index of the hardwired-zero register
package regbank_pkg;

   localparam int DW_DEF    = 32;
   localparam int NREG_DEF  = 32;
   localparam int NREAD_DEF = 2;
   localparam int ZERO_REG  = 0;

endpackage

// File: rtl/reg_bank_sb_read_port.sv
// rb_read_port
// One combinational read port of the register bank: zero-register forcing,
// optional same-cycle write forwarding and the busy flag seen by the reader.
// Ports:
//   addr      in  AW  register being read
//   arr_data  in  DW  array contents for addr (pre-edge)
//   busy_bit  in  1   scoreboard bit for addr (pre-edge)
//   wr0_*     in      ALU writeback (enable already qualified by reset)
//   wr1_*     in      load writeback (enable already qualified by reset)
//   data      out DW  read result
//   busy      out 1   reader must wait for an outstanding load
module rb_read_port
   import regbank_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int AW     = 5,
   parameter int BYPASS = 1
)(
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] arr_data,
   input  logic          busy_bit,
   input  logic          wr0_en,
   input  logic [AW-1:0] wr0_addr,
   input  logic [DW-1:0] wr0_data,
   input  logic          wr1_en,
   input  logic [AW-1:0] wr1_addr,
   input  logic [DW-1:0] wr1_data,
   output logic [DW-1:0] data,
   output logic          busy
);

   always_comb begin
      data = arr_data;
      busy = busy_bit;
      if (addr == AW'(ZERO_REG)) begin
         data = '0;
         busy = 1'b0;
      end else if (BYPASS != 0) begin
         // The load result arriving this cycle is forwarded, so the reader
         // no longer has to wait on it. wr1 is checked first: it wins on
         // a same-address collision, matching the array write priority.
         if (wr1_en && (wr1_addr == addr)) begin
            data = wr1_data;
            busy = 1'b0;
         end else if (wr0_en && (wr0_addr == addr)) begin
            data = wr0_data;
         end
      end
   end

endmodule

// File: rtl/reg_bank_sb.sv
// reg_bank_sb
// Decode-stage register file: NREAD combinational read ports, ALU and load
// writeback ports, optional write-to-read bypass and a per-register busy
// scoreboard tracking outstanding loads. Register 0 reads zero, never busy.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   wr0_*        ALU writeback (en/addr/data)
//   wr1_*        load writeback (en/addr/data), also clears busy
//   rd_addr      packed read addresses, port i at [i*AW +: AW]
//   rd_data      packed read data, port i at [i*DW +: DW]
//   rd_busy      per-port busy flag of the register being read
//   issue_en     a load is issued this cycle
//   issue_dest   destination register of that load
//   issue_stall  issue refused: destination still has a load outstanding
module reg_bank_sb
   import regbank_pkg::*;
#(
   parameter int DW     = DW_DEF,
   parameter int NREG   = NREG_DEF,
   localparam int AW    = $clog2(NREG),
   parameter int NREAD  = NREAD_DEF,
   parameter int BYPASS = 1
)(
   input  logic                clk,
   input  logic                rst,
   input  logic                wr0_en,
   input  logic [AW-1:0]       wr0_addr,
   input  logic [DW-1:0]       wr0_data,
   input  logic                wr1_en,
   input  logic [AW-1:0]       wr1_addr,
   input  logic [DW-1:0]       wr1_data,
   input  logic [NREAD*AW-1:0] rd_addr,
   output logic [NREAD*DW-1:0] rd_data,
   output logic [NREAD-1:0]    rd_busy,
   input  logic                issue_en,
   input  logic [AW-1:0]       issue_dest,
   output logic                issue_stall
);

   // Entry 0 is not stored; it is synthesised as zero by the read ports.
   logic [DW-1:0]   mem [1:NREG-1];
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   logic wr0_act;
   logic wr1_act;
   logic issue_acc;
   logic wr0_en_g;
   logic wr1_en_g;

   // While reset is held, nothing may be forwarded to the readers either.
   assign wr0_en_g  = wr0_en & ~rst;
   assign wr1_en_g  = wr1_en & ~rst;
   assign wr0_act   = wr0_en_g && (wr0_addr != AW'(ZERO_REG));
   assign wr1_act   = wr1_en_g && (wr1_addr != AW'(ZERO_REG));

   // A WAW issue is allowed through when the load it would wait on is
   // retiring in this very cycle.
   assign issue_stall = issue_en && (issue_dest != AW'(ZERO_REG)) &&
                        busy_q[issue_dest] &&
                        !(wr1_en_g && (wr1_addr == issue_dest));
   assign issue_acc   = issue_en && !rst && (issue_dest != AW'(ZERO_REG)) &&
                        !issue_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 1; r < NREG; r++) begin
            mem[r] <= '0;
         end
      end else begin
         // wr1 is applied last so it wins a same-address collision.
         if (wr0_act) mem[wr0_addr] <= wr0_data;
         if (wr1_act) mem[wr1_addr] <= wr1_data;
      end
   end

   // Set after clear: a new load to the retiring register stays outstanding.
   always_comb begin
      busy_d = busy_q;
      if (wr1_act)   busy_d[wr1_addr]   = 1'b0;
      if (issue_acc) busy_d[issue_dest] = 1'b1;
      busy_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [AW-1:0] a;
      logic [DW-1:0] arr;

      assign a = rd_addr[i*AW +: AW];

      always_comb begin
         arr = '0;
         if (a != AW'(ZERO_REG)) arr = mem[a];
      end

      rb_read_port #(
         .DW     (DW),
         .AW     (AW),
         .BYPASS (BYPASS)
      ) u_port (
         .addr     (a),
         .arr_data (arr),
         .busy_bit (busy_q[a]),
         .wr0_en   (wr0_en_g),
         .wr0_addr (wr0_addr),
         .wr0_data (wr0_data),
         .wr1_en   (wr1_en_g),
         .wr1_addr (wr1_addr),
         .wr1_data (wr1_data),
         .data     (rd_data[i*DW +: DW]),
         .busy     (rd_busy[i])
      );
   end

endmodule

// File: tb/tb_reg_bank_sb.sv
// tb_reg_bank_sb
// Directed stimulus with a scoreboard queue: the driver pushes the expected
// combinational outputs for each cycle, a monitor on the falling edge pops
// and compares. A second instance with BYPASS=0 is checked where flagged.
module tb_reg_bank_sb;

   localparam int DW = 32;
   localparam int AW = 5;

   typedef struct {
      string       name;
      logic [63:0] data;
      logic [1:0]  busy;
      logic        stall;
      logic        chk_nb;
      logic [63:0] nb_data;
   } exp_t;

   logic          clk;
   logic          rst;
   logic          wr0_en;
   logic [AW-1:0] wr0_addr;
   logic [DW-1:0] wr0_data;
   logic          wr1_en;
   logic [AW-1:0] wr1_addr;
   logic [DW-1:0] wr1_data;
   logic [9:0]    rd_addr;
   logic [63:0]   rd_data;
   logic [1:0]    rd_busy;
   logic          issue_en;
   logic [AW-1:0] issue_dest;
   logic          issue_stall;
   logic [63:0]   nb_rd_data;
   logic [1:0]    nb_rd_busy;
   logic          nb_issue_stall;

   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   reg_bank_sb #(.DW(32), .NREG(32), .NREAD(2), .BYPASS(1)) dut (
      .clk(clk), .rst(rst),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .issue_en(issue_en), .issue_dest(issue_dest), .issue_stall(issue_stall)
   );

   reg_bank_sb #(.DW(32), .NREG(32), .NREAD(2), .BYPASS(0)) dut_nb (
      .clk(clk), .rst(rst),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
      .issue_en(issue_en), .issue_dest(issue_dest), .issue_stall(nb_issue_stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (q.size() != 0) begin
         exp_t e;
         logic bad;
         e = q.pop_front();
         checks++;
         bad = (rd_data !== e.data) || (rd_busy !== e.busy) ||
               (issue_stall !== e.stall);
         if (e.chk_nb)
            bad = bad || (nb_rd_data !== e.nb_data) ||
                  (nb_rd_busy !== e.busy) || (nb_issue_stall !== e.stall);
         if (bad) begin
            errors++;
            $display("FAIL %s: got data=%h busy=%b stall=%b nb_data=%h, want data=%h busy=%b stall=%b nb_data=%h",
                     e.name, rd_data, rd_busy, issue_stall, nb_rd_data,
                     e.data, e.busy, e.stall, e.nb_data);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
      wr0_en = 1'b0; wr1_en = 1'b0; issue_en = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [31:0] d1,
                             input logic [31:0] d0, input logic [1:0] b,
                             input logic s);
      exp_t e;
      e.name = name; e.data = {d1, d0}; e.busy = b; e.stall = s;
      e.chk_nb = 1'b0; e.nb_data = '0;
      q.push_back(e);
   endtask

   task automatic expect_nb(input string name, input logic [31:0] d1,
                            input logic [31:0] d0, input logic [31:0] n1,
                            input logic [31:0] n0);
      exp_t e;
      e.name = name; e.data = {d1, d0}; e.busy = 2'b00; e.stall = 1'b0;
      e.chk_nb = 1'b1; e.nb_data = {n1, n0};
      q.push_back(e);
   endtask

   task automatic rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
      rd_addr = {a1, a0};
   endtask

   initial begin
      rst = 1'b1;
      wr0_en = 0; wr0_addr = '0; wr0_data = '0;
      wr1_en = 0; wr1_addr = '0; wr1_data = '0;
      issue_en = 0; issue_dest = '0; rd_addr = '0;

      // Reset held: outputs quiet.
      next_cycle();
      expect_out("reset_hold", 0, 0, 2'b00, 1'b0);
      next_cycle();
      rst = 1'b0;

      // Every register reads zero and idle after reset.
      for (int r = 0; r < 32; r++) begin
         next_cycle();
         rd(AW'(r), AW'(r));
         expect_out("reset_read", 0, 0, 2'b00, 1'b0);
      end

      // wr0 x5, then a write to x0 that must be dropped.
      next_cycle();
      wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; rd(5, 5);
      expect_out("x5_bypass", 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 1'b0);
      next_cycle();
      wr0_en = 1; wr0_addr = 0; wr0_data = 32'h1234; rd(0, 5);
      expect_out("x0_write_same", 0, 32'hDEADBEEF, 2'b00, 1'b0);
      next_cycle();
      rd(0, 5);
      expect_out("x0_write_after", 0, 32'hDEADBEEF, 2'b00, 1'b0);

      // wr0/wr1 collision on x7: wr1 wins, bypass vs pre-edge contents.
      next_cycle();
      wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11;
      wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22; rd(7, 7);
      expect_nb("x7_collide", 32'h22, 32'h22, 0, 0);
      next_cycle();
      rd(7, 7);
      expect_nb("x7_after", 32'h22, 32'h22, 32'h22, 32'h22);

      // Scoreboard on x9.
      next_cycle();
      issue_en = 1; issue_dest = 9; rd(9, 9);
      expect_out("x9_issue", 0, 0, 2'b00, 1'b0);
      next_cycle();
      issue_en = 1; issue_dest = 9; rd(9, 0);
      expect_out("x9_reissue_stall", 0, 0, 2'b10, 1'b1);
      next_cycle();
      issue_en = 1; issue_dest = 9;
      wr1_en = 1; wr1_addr = 9; wr1_data = 32'h55; rd(9, 9);
      expect_out("x9_issue_with_wr1", 32'h55, 32'h55, 2'b00, 1'b0);
      next_cycle();
      rd(9, 9);
      expect_out("x9_still_busy", 32'h55, 32'h55, 2'b11, 1'b0);
      next_cycle();
      wr1_en = 1; wr1_addr = 9; wr1_data = 32'h66; rd(9, 9);
      expect_out("x9_wr1_fwd", 32'h66, 32'h66, 2'b00, 1'b0);
      next_cycle();
      rd(9, 9);
      expect_out("x9_retired", 32'h66, 32'h66, 2'b00, 1'b0);

      // ALU write to a busy register keeps it busy.
      next_cycle();
      issue_en = 1; issue_dest = 10; rd(10, 10);
      expect_out("x10_issue", 0, 0, 2'b00, 1'b0);
      next_cycle();
      wr0_en = 1; wr0_addr = 10; wr0_data = 32'hAB; rd(10, 9);
      expect_out("x10_wr0_busy", 32'hAB, 32'h66, 2'b10, 1'b0);
      next_cycle();
      rd(10, 10);
      expect_out("x10_stays_busy", 32'hAB, 32'hAB, 2'b11, 1'b0);

      // Issue to x0 is never a hazard and never sets busy.
      next_cycle();
      issue_en = 1; issue_dest = 0; rd(0, 0);
      expect_out("x0_issue", 0, 0, 2'b00, 1'b0);
      next_cycle();
      rd(0, 0);
      expect_out("x0_not_busy", 0, 0, 2'b00, 1'b0);

      // Mid-cycle asynchronous reset with x3 busy and holding 0xA5.
      next_cycle();
      issue_en = 1; issue_dest = 3;
      wr0_en = 1; wr0_addr = 3; wr0_data = 32'hA5; rd(3, 3);
      expect_out("x3_setup", 32'hA5, 32'hA5, 2'b00, 1'b0);
      next_cycle();
      issue_en = 1; issue_dest = 3; rd(3, 3);
      expect_out("x3_busy", 32'hA5, 32'hA5, 2'b11, 1'b1);
      next_cycle();
      rst = 1;
      issue_en = 1; issue_dest = 3;
      wr0_en = 1; wr0_addr = 4; wr0_data = 32'h77; rd(4, 3);
      expect_out("async_rst", 0, 0, 2'b00, 1'b0);
      next_cycle();
      rst = 0; rd(4, 3);
      expect_out("rst_write_ignored", 0, 0, 2'b00, 1'b0);
      next_cycle();
      wr1_en = 1; wr1_addr = 3; wr1_data = 32'h1; rd(3, 3);
      expect_out("x3_plain_wr1", 32'h1, 32'h1, 2'b00, 1'b0);
      next_cycle();
      rd(3, 3);
      expect_out("x3_after_wr1", 32'h1, 32'h1, 2'b00, 1'b0);

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
